host_load_sequencer: RTL and testbench
======================================

// Module: host_load_sequencer
// PURPOSE
//  Host-side controller between the Tiny Tapeout pins and the tpu core. Samples a
//  3-bit command and 5-bit address from uio_in[7:5]/[4:0] and a data byte from ui_in
//  every cycle; turns load bursts into addressed write strobes for the weight, input
//  and instruction memories; sequences start/run/done of the core with a watchdog.
// PARAMETERS
//  DATA_W      8    data byte width
//  ADDR_W      5    host address width
//  W_DEPTH     4    weight memory entries
//  INP_DEPTH   4    input memory entries
//  INS_DEPTH   16   instruction memory entries
//  RUN_TMO     255  max cycles in RUN before watchdog error (counter width = $clog2(RUN_TMO+1))
// PORTS
//  clk          in   1       clock
//  rst_n        in   1       asynchronous reset, active low
//  data_in      in   DATA_W  host data byte (ui_in)
//  cmd_in       in   3       host command (uio_in[7:5])
//  addr_in      in   ADDR_W  burst base address (uio_in[4:0])
//  core_done    in   1       core finished program (level or pulse)
//  mem_we_w     out  1       weight memory write strobe
//  mem_we_inp   out  1       input memory write strobe
//  mem_we_ins   out  1       instruction memory write strobe
//  mem_addr     out  ADDR_W  write address (shared by all three memories)
//  mem_wdata    out  DATA_W  write data
//  core_start   out  1       one-cycle start pulse to core
//  core_abort   out  1       one-cycle abort pulse to core
//  busy         out  1       high in RUN
//  done         out  1       high in DONE
//  err          out  1       sticky error; cleared by ABORT or reset
// BEHAVIOUR
//  Commands: 000 NOP, 001 LOAD_W, 010 LOAD_INP, 011 LOAD_INS, 100 START, 101 ABORT,
//   110/111 treated as NOP. All outputs registered; reset drives every output to 0,
//   state IDLE, address counter 0, previous-command register NOP.
//  States: IDLE, LOAD, RUN, DONE.
//  LOAD_x seen in IDLE/LOAD/DONE: enter LOAD. First cycle of a burst (cmd_in differs
//   from previous sampled cmd) writes at addr_in; each further cycle with the same cmd
//   writes at previous address+1, wrapping to 0 after DEPTH_x-1. One write per cycle;
//   strobe, mem_addr, mem_wdata appear 1 cycle after the sampling edge.
//  Base address >= DEPTH_x: no strobe for that cycle, err set; burst continues from
//   addr_in on the next first-cycle only (no writes until a new valid burst).
//  Switching directly LOAD_W -> LOAD_INP counts as a new burst (new base from addr_in).
//  NOP in LOAD: return to IDLE, no strobe.
//  START in IDLE/LOAD/DONE: core_start=1 for exactly one cycle, enter RUN, clear
//   watchdog; repeated START while cmd held is ignored (edge-detected on cmd change).
//  RUN: busy=1; loads and START ignored and set err; watchdog increments each cycle.
//   core_done=1 -> DONE next cycle (busy=0, done=1). Watchdog reaching RUN_TMO ->
//   err=1, core_abort pulse, IDLE. core_done and watchdog expiry same cycle: done wins.
//  DONE: done held until next non-NOP command, which is then processed as from IDLE.
//  ABORT any state: core_abort pulse (only if leaving RUN), err cleared, IDLE, no strobe.
//  Async reset mid-burst or mid-run: immediate return to reset values; no pulse issued.
// STRUCTURE
//  Shared package tpu_pkg: typedef enum cmd_e (3-bit codes above), typedef enum
//   seq_state_e, depth constants W_DEPTH/INP_DEPTH/INS_DEPTH.
//  One sub-module: burst_addr_gen (base load, increment, wrap at runtime depth,
//   range check) instantiated once; FSM, watchdog and output registers stay in top.
// TESTING
//  LOAD_W base 0, data 11,22,33,44,55 over 5 cycles -> we_w at addr 0,1,2,3,0 with
//   those bytes, 1-cycle latency.
//  LOAD_INS base 3 for 2 cycles, then LOAD_INP base 1 for 1 cycle -> ins addr 3,4;
//   inp addr 1; no strobe on other memories.
//  LOAD_INP base 6 -> no strobe, err=1; ABORT -> err=0.
//  START held 3 cycles -> single core_start; busy=1; core_done after 10 cycles ->
//   done=1, busy=0; LOAD_W during RUN -> no strobe, err=1.
//  START, no core_done for RUN_TMO cycles -> err=1, core_abort pulse, back to IDLE.
//  rst_n low mid-burst and mid-run -> all outputs 0 same cycle; first command after
//   release behaves as from IDLE.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared types and constants for the host-side sequencer of the tpu core.
//  cmd_e        : 3-bit host command codes sampled from uio_in[7:5]
//  seq_state_e  : sequencer FSM states
//  *_DEPTH      : entry counts of the weight, input and instruction memories
package tpu_pkg;

    typedef enum logic [2:0] {
        CMD_NOP      = 3'b000,
        CMD_LOAD_W   = 3'b001,
        CMD_LOAD_INP = 3'b010,
        CMD_LOAD_INS = 3'b011,
        CMD_START    = 3'b100,
        CMD_ABORT    = 3'b101,
        CMD_RSV6     = 3'b110,
        CMD_RSV7     = 3'b111
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } seq_state_e;

    localparam int W_DEPTH   = 4;
    localparam int INP_DEPTH = 4;
    localparam int INS_DEPTH = 16;

    // True for the three memory-load commands.
    function automatic logic is_load_cmd(input cmd_e cmd);
        return (cmd == CMD_LOAD_W) || (cmd == CMD_LOAD_INP) || (cmd == CMD_LOAD_INS);
    endfunction

endpackage

// File: rtl/host_load_sequencer_burst_addr_gen.sv
// Burst address generator: produces the write address for the current load
// cycle. On the first cycle of a burst the base address is used directly;
// on later cycles the last written address is incremented, wrapping to 0 at
// the runtime depth of the selected memory. Also range-checks the base.
// Ports:
//  clk, rst_n  clock, asynchronous active-low reset
//  first       current cycle starts a new burst (use base)
//  step        current cycle continues an accepted burst (advance)
//  base        burst base address from the host
//  depth       entry count of the memory being loaded
//  wr_addr     address for this cycle (combinational)
//  base_ok     base lies inside the selected memory
module burst_addr_gen #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              first,
    input  logic              step,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   depth,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              base_ok
);

    logic [ADDR_W-1:0] cur_r;
    logic [ADDR_W:0]   cur_inc_s;
    logic              update_s;

    // Select base or wrapped increment and decide whether the counter moves.
    always_comb begin
        base_ok   = ({1'b0, base} < depth);
        cur_inc_s = {1'b0, cur_r} + {{ADDR_W{1'b0}}, 1'b1};
        if (first) begin
            wr_addr = base;
        end else if (cur_inc_s >= depth) begin
            wr_addr = {ADDR_W{1'b0}};
        end else begin
            wr_addr = cur_inc_s[ADDR_W-1:0];
        end
        // A rejected base must not disturb the counter.
        update_s = (first && base_ok) || (!first && step);
    end

    // Last address actually written in the current burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_r <= {ADDR_W{1'b0}};
        end else if (update_s) begin
            cur_r <= wr_addr;
        end else begin
            cur_r <= cur_r;
        end
    end

endmodule

// File: rtl/host_load_sequencer.sv
// Host-side controller between the Tiny Tapeout pins and the tpu core.
// Samples command/address/data each cycle, converts load bursts into
// addressed write strobes for the three memories, and sequences
// start/run/done of the core with a run watchdog. All outputs registered.
// Ports:
//  clk, rst_n                 clock, asynchronous active-low reset
//  data_in                    host data byte
//  cmd_in                     host command
//  addr_in                    burst base address
//  core_done                  core finished (level or pulse)
//  mem_we_w/_inp/_ins         per-memory write strobes
//  mem_addr, mem_wdata        shared write address and data
//  core_start, core_abort     one-cycle control pulses to the core
//  busy, done, err            RUN indicator, DONE indicator, sticky error
module host_load_sequencer #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 5,
    parameter int W_DEPTH   = tpu_pkg::W_DEPTH,
    parameter int INP_DEPTH = tpu_pkg::INP_DEPTH,
    parameter int INS_DEPTH = tpu_pkg::INS_DEPTH,
    parameter int RUN_TMO   = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic [2:0]        cmd_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              core_done,
    output logic              mem_we_w,
    output logic              mem_we_inp,
    output logic              mem_we_ins,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              core_start,
    output logic              core_abort,
    output logic              busy,
    output logic              done,
    output logic              err
);

    import tpu_pkg::*;

    localparam int WD_W = $clog2(RUN_TMO + 1);
    localparam logic [WD_W:0]   TMO_C       = (WD_W + 1)'(RUN_TMO);
    localparam logic [ADDR_W:0] W_DEPTH_C   = (ADDR_W + 1)'(W_DEPTH);
    localparam logic [ADDR_W:0] INP_DEPTH_C = (ADDR_W + 1)'(INP_DEPTH);
    localparam logic [ADDR_W:0] INS_DEPTH_C = (ADDR_W + 1)'(INS_DEPTH);

    seq_state_e        state_r, state_nxt_s;
    cmd_e              prev_cmd_r, cmd_s;
    logic [WD_W-1:0]   wdog_r, wdog_nxt_s;
    logic [WD_W:0]     wdog_inc_s;
    logic              err_r, err_nxt_s;
    logic              burst_ok_r, burst_ok_nxt_s;
    logic              start_nxt_s, abort_nxt_s;
    logic              cmd_new_s, is_load_s, first_s, step_s, gen_first_s;
    logic              load_allowed_s, write_s;
    logic              we_w_s, we_inp_s, we_ins_s;
    logic [ADDR_W:0]   depth_s;
    logic [ADDR_W-1:0] wr_addr_s;
    logic              base_ok_s;

    logic              mem_we_w_r, mem_we_inp_r, mem_we_ins_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic              core_start_r, core_abort_r, busy_r, done_r;

    // Command decode, burst classification and write-strobe generation.
    always_comb begin
        cmd_s          = cmd_e'(cmd_in);
        cmd_new_s      = (cmd_in != prev_cmd_r);
        is_load_s      = is_load_cmd(cmd_s);
        load_allowed_s = (state_r != ST_RUN);
        // Outside LOAD any load command starts afresh; inside LOAD only a
        // change of command (including between memories) does.
        first_s        = is_load_s && (cmd_new_s || (state_r != ST_LOAD));
        gen_first_s    = first_s && load_allowed_s;
        step_s         = load_allowed_s && is_load_s && !first_s && burst_ok_r;
        if (first_s) begin
            write_s = load_allowed_s && base_ok_s;
        end else begin
            write_s = step_s;
        end
        case (cmd_s)
            CMD_LOAD_INP: depth_s = INP_DEPTH_C;
            CMD_LOAD_INS: depth_s = INS_DEPTH_C;
            default:      depth_s = W_DEPTH_C;
        endcase
        we_w_s   = write_s && (cmd_s == CMD_LOAD_W);
        we_inp_s = write_s && (cmd_s == CMD_LOAD_INP);
        we_ins_s = write_s && (cmd_s == CMD_LOAD_INS);
    end

    burst_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_burst_addr_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .first   (gen_first_s),
        .step    (step_s),
        .base    (addr_in),
        .depth   (depth_s),
        .wr_addr (wr_addr_s),
        .base_ok (base_ok_s)
    );

    // Sequencer next-state, error, watchdog and control-pulse logic.
    always_comb begin
        state_nxt_s    = state_r;
        err_nxt_s      = err_r;
        start_nxt_s    = 1'b0;
        abort_nxt_s    = 1'b0;
        wdog_nxt_s     = wdog_r;
        burst_ok_nxt_s = burst_ok_r;
        wdog_inc_s     = {1'b0, wdog_r} + {{WD_W{1'b0}}, 1'b1};
        case (state_r)
            ST_IDLE, ST_LOAD, ST_DONE: begin
                case (cmd_s)
                    CMD_LOAD_W, CMD_LOAD_INP, CMD_LOAD_INS: begin
                        state_nxt_s = ST_LOAD;
                        if (first_s) begin
                            // A bad base blocks the rest of this burst.
                            burst_ok_nxt_s = base_ok_s;
                            if (!base_ok_s) begin
                                err_nxt_s = 1'b1;
                            end else begin
                                err_nxt_s = err_r;
                            end
                        end else begin
                            burst_ok_nxt_s = burst_ok_r;
                        end
                    end
                    CMD_START: begin
                        // Held START does not retrigger the core.
                        if (cmd_new_s) begin
                            start_nxt_s = 1'b1;
                            state_nxt_s = ST_RUN;
                            wdog_nxt_s  = {WD_W{1'b0}};
                        end else begin
                            state_nxt_s = state_r;
                        end
                    end
                    CMD_ABORT: begin
                        state_nxt_s = ST_IDLE;
                        err_nxt_s   = 1'b0;
                    end
                    default: begin
                        if (state_r == ST_LOAD) begin
                            state_nxt_s = ST_IDLE;
                        end else begin
                            state_nxt_s = state_r;
                        end
                    end
                endcase
            end
            ST_RUN: begin
                if (cmd_s == CMD_ABORT) begin
                    abort_nxt_s = 1'b1;
                    err_nxt_s   = 1'b0;
                    state_nxt_s = ST_IDLE;
                end else begin
                    if ((is_load_s || (cmd_s == CMD_START)) && cmd_new_s) begin
                        err_nxt_s = 1'b1;
                    end else begin
                        err_nxt_s = err_r;
                    end
                    // Completion takes priority over a simultaneous timeout.
                    if (core_done) begin
                        state_nxt_s = ST_DONE;
                    end else if (wdog_inc_s == TMO_C) begin
                        err_nxt_s   = 1'b1;
                        abort_nxt_s = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        wdog_nxt_s = wdog_inc_s[WD_W-1:0];
                    end
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Sequencer state, command history and watchdog registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            prev_cmd_r <= CMD_NOP;
            wdog_r     <= {WD_W{1'b0}};
            err_r      <= 1'b0;
            burst_ok_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            prev_cmd_r <= cmd_s;
            wdog_r     <= wdog_nxt_s;
            err_r      <= err_nxt_s;
            burst_ok_r <= burst_ok_nxt_s;
        end
    end

    // Output registers; address and data hold their last written value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we_w_r   <= 1'b0;
            mem_we_inp_r <= 1'b0;
            mem_we_ins_r <= 1'b0;
            mem_addr_r   <= {ADDR_W{1'b0}};
            mem_wdata_r  <= {DATA_W{1'b0}};
            core_start_r <= 1'b0;
            core_abort_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            mem_we_w_r   <= we_w_s;
            mem_we_inp_r <= we_inp_s;
            mem_we_ins_r <= we_ins_s;
            if (write_s) begin
                mem_addr_r  <= wr_addr_s;
                mem_wdata_r <= data_in;
            end else begin
                mem_addr_r  <= mem_addr_r;
                mem_wdata_r <= mem_wdata_r;
            end
            core_start_r <= start_nxt_s;
            core_abort_r <= abort_nxt_s;
            busy_r       <= (state_nxt_s == ST_RUN);
            done_r       <= (state_nxt_s == ST_DONE);
        end
    end

    assign mem_we_w   = mem_we_w_r;
    assign mem_we_inp = mem_we_inp_r;
    assign mem_we_ins = mem_we_ins_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;
    assign core_start = core_start_r;
    assign core_abort = core_abort_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign err        = err_r;

endmodule

// File: tb/tb_host_load_sequencer.sv
// Directed testbench for host_load_sequencer. All DUT outputs are packed
// into one vector {we_w,we_inp,we_ins,addr,wdata,start,abort,busy,done,err}
// and compared against hand-computed expectations.
module tb_host_load_sequencer;

    import tpu_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [7:0] data_in;
    logic [2:0] cmd_in;
    logic [4:0] addr_in;
    logic       core_done;
    logic       mem_we_w, mem_we_inp, mem_we_ins;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       core_start, core_abort, busy, done, err;

    int tests_run;
    int tests_failed;

    // held address / data seen on the bus when no strobe is issued
    logic [4:0] ha;
    logic [7:0] hd;

    host_load_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .cmd_in     (cmd_in),
        .addr_in    (addr_in),
        .core_done  (core_done),
        .mem_we_w   (mem_we_w),
        .mem_we_inp (mem_we_inp),
        .mem_we_ins (mem_we_ins),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .core_start (core_start),
        .core_abort (core_abort),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [20:0] outs();
        return {mem_we_w, mem_we_inp, mem_we_ins, mem_addr, mem_wdata,
                core_start, core_abort, busy, done, err};
    endfunction

    function automatic logic [20:0] ev(input logic [2:0] we, input logic [4:0] a,
                                       input logic [7:0] d, input logic st,
                                       input logic ab, input logic bz,
                                       input logic dn, input logic er);
        return {we, a, d, st, ab, bz, dn, er};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; data_in = 8'h00; cmd_in = CMD_NOP; addr_in = 5'd0; core_done = 1'b0;
        ha = 5'd0; hd = 8'h00;
        #3;
        tests_run++;
        if (outs() !== 21'h0) begin
            tests_failed++;
            $display("FAIL reset: got %h want %h", outs(), 21'h0);
        end
        @(posedge clk); #2;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_load_w();
        logic [7:0] d [5];
        logic [4:0] a [5];
        logic [20:0] e;
        d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33; d[3] = 8'h44; d[4] = 8'h55;
        a[0] = 5'd0;  a[1] = 5'd1;  a[2] = 5'd2;  a[3] = 5'd3;  a[4] = 5'd0;
        for (int i = 0; i < 5; i++) begin
            cmd_in = CMD_LOAD_W; addr_in = 5'd0; data_in = d[i];
            step();
            e = ev(3'b100, a[i], d[i], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            ha = a[i]; hd = d[i];
            tests_run++;
            if (outs() !== e) begin
                tests_failed++;
                $display("FAIL load_w beat %0d: got %h want %h", i, outs(), e);
            end
        end
        cmd_in = CMD_NOP;
        step();
        e = ev(3'b000, ha, hd, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (outs() !== e) begin
            tests_failed++;
            $display("FAIL load_w nop: got %h want %h", outs(), e);
        end
    endtask

    task automatic test_load_ins_inp();
        logic [20:0] e;
        cmd_in = CMD_LOAD_INS; addr_in = 5'd3; data_in = 8'hAA;
        step();
        e = ev(3'b001, 5'd3, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (outs() !== e) begin tests_failed++; $display("FAIL ins beat0: got %h want %h", outs(), e); end
        addr_in = 5'd9; data_in = 8'hBB;
        step();
        e = ev(3'b001, 5'd4, 8'hBB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (outs() !== e) begin tests_failed++; $display("FAIL ins beat1: got %h want %h", outs(), e); end
        cmd_in = CMD_LOAD_INP; addr_in = 5'd1; data_in = 8'hCC;
        step();
        e = ev(3'b010, 5'd1, 8'hCC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        ha = 5'd1; hd = 8'hCC;
        tests_run++;
        if (outs() !== e) begin tests_failed++; $display("FAIL inp switch: got %h want %h", outs(), e); end
        cmd_in = CMD_NOP;
        step();
    endtask

    task automatic test_bad_base();
        logic [20:0] e;
        cmd_in = CMD_LOAD_INP; addr_in = 5'd6; data_in = 8'hDD;
        step();
        e = ev(3'b000, ha, hd, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tests_run++;
        if (outs() !== e) begin tests_failed++; $display("FAIL bad base: got %h want %h", outs(), e); end
        addr_in = 5'd0; data_in = 8'hEE;
        step();
        tests_run++;
        if (outs() !== e) begin tests_failed++; $display("FAIL bad base hold: got %h want %h", outs(), e); end
        cmd_in = CMD_ABORT;
        step();
        e = ev(3'b000, ha, hd, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (outs() !== e) begin tests_failed++; $display("FAIL abort clears err: got %h want %h", outs(), e); end
        cmd_in = CMD_NOP;
        step();
    endtask

    task automatic test_run();
        logic [20:0] e;
        cmd_in = CMD_START;
        step();
        e = ev(3'b000, ha, hd, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tests_run++;
        if (outs() !== e) begin tests_failed++; $display("FAIL start pulse: got %h want %h", outs(), e); end
        e = ev(3'b000, ha, hd, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step();
            tests_run++;
            if (outs() !== e) begin tests_failed++; $display("FAIL start held %0d: got %h want %h", i, outs(), e); end
        end
        cmd_in = CMD_NOP;
        step();
        cmd_in = CMD_LOAD_W; addr_in = 5'd0; data_in = 8'h77;
        step();
        e = ev(3'b000, ha, hd, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        tests_run++;
        if (outs() !== e) begin tests_failed++; $display("FAIL load in run: got %h want %h", outs(), e); end
        cmd_in = CMD_NOP;
        for (int i = 0; i < 4; i++) step();
        core_done = 1'b1;
        step();
        core_done = 1'b0;
        e = ev(3'b000, ha, hd, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        tests_run++;
        if (outs() !== e) begin tests_failed++; $display("FAIL done: got %h want %h", outs(), e); end
        step();
        step();
        tests_run++;
        if (outs() !== e) begin tests_failed++; $display("FAIL done held: got %h want %h", outs(), e); end
        cmd_in = CMD_ABORT;
        step();
        e = ev(3'b000, ha, hd, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (outs() !== e) begin tests_failed++; $display("FAIL abort from done: got %h want %h", outs(), e); end
        cmd_in = CMD_NOP;
        step();
    endtask

    task automatic test_abort_run();
        logic [20:0] e;
        cmd_in = CMD_START;
        step();
        cmd_in = CMD_ABORT;
        step();
        e = ev(3'b000, ha, hd, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (outs() !== e) begin tests_failed++; $display("FAIL abort in run: got %h want %h", outs(), e); end
        cmd_in = CMD_NOP;
        step();
        e = ev(3'b000, ha, hd, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (outs() !== e) begin tests_failed++; $display("FAIL abort one pulse: got %h want %h", outs(), e); end
    endtask

    task automatic test_watchdog();
        logic [20:0] e;
        logic bad;
        bad = 1'b0;
        cmd_in = CMD_START;
        step();
        cmd_in = CMD_NOP;
        for (int k = 1; k < 255; k++) begin
            step();
            if (busy !== 1'b1 || core_abort !== 1'b0) bad = 1'b1;
        end
        tests_run++;
        if (bad !== 1'b0) begin tests_failed++; $display("FAIL wdog early: got %b want %b", bad, 1'b0); end
        step();
        e = ev(3'b000, ha, hd, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        tests_run++;
        if (outs() !== e) begin tests_failed++; $display("FAIL wdog expire: got %h want %h", outs(), e); end
        step();
        e = ev(3'b000, ha, hd, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tests_run++;
        if (outs() !== e) begin tests_failed++; $display("FAIL wdog idle: got %h want %h", outs(), e); end
        cmd_in = CMD_ABORT;
        step();
        cmd_in = CMD_NOP;
        step();
    endtask

    task automatic test_done_wins();
        logic [20:0] e;
        cmd_in = CMD_START;
        step();
        cmd_in = CMD_NOP;
        for (int k = 1; k < 255; k++) step();
        core_done = 1'b1;
        step();
        core_done = 1'b0;
        e = ev(3'b000, ha, hd, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tests_run++;
        if (outs() !== e) begin tests_failed++; $display("FAIL done vs wdog: got %h want %h", outs(), e); end
        cmd_in = CMD_ABORT;
        step();
        cmd_in = CMD_NOP;
        step();
    endtask

    task automatic test_async_reset();
        logic [20:0] e;
        cmd_in = CMD_LOAD_W; addr_in = 5'd1; data_in = 8'h12;
        step();
        data_in = 8'h34;
        step();
        e = ev(3'b100, 5'd2, 8'h34, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (outs() !== e) begin tests_failed++; $display("FAIL pre-reset burst: got %h want %h", outs(), e); end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (outs() !== 21'h0) begin tests_failed++; $display("FAIL reset mid-burst: got %h want %h", outs(), 21'h0); end
        rst_n = 1'b1;
        data_in = 8'h56;
        step();
        e = ev(3'b100, 5'd1, 8'h56, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (outs() !== e) begin tests_failed++; $display("FAIL burst after reset: got %h want %h", outs(), e); end
        cmd_in = CMD_NOP;
        step();
        cmd_in = CMD_START;
        step();
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (outs() !== 21'h0) begin tests_failed++; $display("FAIL reset mid-run: got %h want %h", outs(), 21'h0); end
        rst_n = 1'b1;
        step();
        e = ev(3'b000, 5'd0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tests_run++;
        if (outs() !== e) begin tests_failed++; $display("FAIL start after reset: got %h want %h", outs(), e); end
        cmd_in = CMD_ABORT;
        step();
        e = ev(3'b000, 5'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (outs() !== e) begin tests_failed++; $display("FAIL abort after reset: got %h want %h", outs(), e); end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_load_w();
        test_load_ins_inp();
        test_bad_base();
        test_run();
        test_abort_run();
        test_watchdog();
        test_done_wins();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
